// File: rtl/vga_state_fetcher_if.sv
// ----------------------------------------------------------------------------
// vga_state_fetcher_if
//
// Bundles the signals between the VGA state fetcher and its neighbours:
// the frame_start strobe from the VGA timing block, dmem port B (address out,
// read data in), the renderer's committed-bank read port, and the status
// pulses.
//
//   master : the fetcher itself (drives address, rd_data and status).
//   slave  : the surrounding system (timing block, dmem port B, renderer).
//
// Signals
//   frame_start       1      start-of-vblank pulse
//   VGA_address_dmem  12     dmem port-B word address
//   VGA_q_dmem        32     dmem port-B read data
//   rd_index          IDX_W  committed-bank word select
//   rd_data           32     committed-bank word at rd_index
//   busy              1      fetch in progress
//   frame_ready       1      one-cycle pulse, new bank committed
//   overrun           1      one-cycle pulse, frame_start dropped
// ----------------------------------------------------------------------------
interface vga_state_fetcher_if #(
  parameter int IDX_W = 3
);
  logic             frame_start;
  logic [11:0]      VGA_address_dmem;
  logic [31:0]      VGA_q_dmem;
  logic [IDX_W-1:0] rd_index;
  logic [31:0]      rd_data;
  logic             busy;
  logic             frame_ready;
  logic             overrun;

  modport master (
    input  frame_start,
    input  VGA_q_dmem,
    input  rd_index,
    output VGA_address_dmem,
    output rd_data,
    output busy,
    output frame_ready,
    output overrun
  );

  modport slave (
    output frame_start,
    output VGA_q_dmem,
    output rd_index,
    input  VGA_address_dmem,
    input  rd_data,
    input  busy,
    input  frame_ready,
    input  overrun
  );
endinterface

// File: rtl/vga_state_fetcher.sv
// ----------------------------------------------------------------------------
// vga_state_fetcher
//
// Read-only client of dmem port B. On every frame_start pulse it burst-reads
// NUM_WORDS consecutive words starting at BASE_ADDR (game state: positions,
// score, flags) into a shadow buffer, one address per cycle with the returned
// data captured READ_LATENCY edges later. Once the last word is captured the
// whole shadow is copied into the committed bank in a single edge and
// frame_ready pulses, so the renderer never sees a half-updated frame.
//
// Parameters
//   BASE_ADDR     dmem word address of state word 0 (12-bit, wraps mod 4096)
//   NUM_WORDS     words fetched per frame (1..2^IDX_W)
//   IDX_W         width of rd_index
//   READ_LATENCY  edges from address presentation to data capture (1..4)
//
// Ports
//   clock   master clock, shared with dmem clock_b
//   reset   synchronous, active-high; aborts any burst, zeroes both banks
//   bus     vga_state_fetcher_if.master (see interface header)
//
// Timing, with E0 the edge that samples frame_start in IDLE:
//   address BASE_ADDR+k is presented during the cycle after edge E0+k,
//   word k lands in shadow on edge E0+k+READ_LATENCY, and the commit plus
//   frame_ready happen on edge E0+NUM_WORDS+READ_LATENCY.
// ----------------------------------------------------------------------------
module vga_state_fetcher #(
  parameter logic [11:0] BASE_ADDR    = 12'd1024,
  parameter int          NUM_WORDS    = 8,
  parameter int          IDX_W        = 3,
  parameter int          READ_LATENCY = 2
) (
  input logic               clock,
  input logic               reset,
  vga_state_fetcher_if.master bus
);

  localparam int DATA_W = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [11:0]        addr, addr_d;
  logic [IDX_W-1:0]   cnt, cnt_d;
  logic               busy, busy_d;
  logic               frame_ready, frame_ready_d;
  logic               overrun, overrun_d;
  logic               commit_en;

  logic               issue_vld;
  logic               cap_vld;
  logic [IDX_W-1:0]   cap_idx;
  logic               last_cap;

  logic [DATA_W-1:0]  shadow [0:NUM_WORDS-1];
  logic [DATA_W-1:0]  bank   [0:NUM_WORDS-1];

  // A read is issued in every ISSUE cycle; cnt is the word index of the
  // address currently on the bus.
  assign issue_vld = (state == ISSUE);

  // --- stage boundary: issue -> capture (READ_LATENCY-deep tracking) ---
  // The capture edge for a read issued in cycle k is E0+k+READ_LATENCY, so
  // the tracking pipe holds READ_LATENCY-1 registers and the capture decision
  // is taken from its last stage. With a latency of one the issue itself is
  // the capture qualifier.
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign cap_vld = issue_vld;
      assign cap_idx = cnt;
    end else begin : g_latn
      logic [READ_LATENCY-2:0] vld_p;
      logic [IDX_W-1:0]        idx_p [0:READ_LATENCY-2];

      // Valid is control: cleared by reset so an aborted burst leaves no
      // stray captures behind.
      always_ff @(posedge clock) begin
        if (reset) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= issue_vld;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            vld_p[i] <= vld_p[i-1];
          end
        end
      end

      // Index only matters when qualified by vld_p, so it carries no reset.
      always_ff @(posedge clock) begin
        idx_p[0] <= cnt;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          idx_p[i] <= idx_p[i-1];
        end
      end

      assign cap_vld = vld_p[READ_LATENCY-2];
      assign cap_idx = idx_p[READ_LATENCY-2];
    end
  endgenerate

  assign last_cap = cap_vld && (cap_idx == LAST_IDX);

  // --- FSM next-state and registered-output decode ---
  always_comb begin
    state_d       = state;
    addr_d        = addr;
    cnt_d         = cnt;
    busy_d        = busy;
    frame_ready_d = 1'b0;
    overrun_d     = 1'b0;
    commit_en     = 1'b0;

    case (state)
      IDLE: begin
        addr_d = BASE_ADDR;
        cnt_d  = '0;
        if (bus.frame_start) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
        end
      end

      ISSUE: begin
        overrun_d = bus.frame_start;
        if (cnt == LAST_IDX) begin
          // Address freezes on the last word. With a one-edge latency the
          // last word is captured on this same edge, so DRAIN is skipped.
          state_d = last_cap ? COMMIT : DRAIN;
        end else begin
          cnt_d  = cnt + IDX_W'(1);
          addr_d = addr + 12'd1;
        end
      end

      DRAIN: begin
        overrun_d = bus.frame_start;
        if (last_cap) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        overrun_d     = bus.frame_start;
        commit_en     = 1'b1;
        frame_ready_d = 1'b1;
        busy_d        = 1'b0;
        addr_d        = BASE_ADDR;
        cnt_d         = '0;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
        addr_d  = BASE_ADDR;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --- stage boundary: FSM / address register ---
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= BASE_ADDR;
      cnt         <= '0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      cnt         <= cnt_d;
      busy        <= busy_d;
      frame_ready <= frame_ready_d;
      overrun     <= overrun_d;
    end
  end

  // --- stage boundary: shadow capture ---
  // Both banks are cleared on reset so the renderer sees an all-zero frame
  // after an aborted burst rather than stale or partial state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow[i] <= '0;
      end
    end else if (cap_vld) begin
      shadow[cap_idx] <= bus.VGA_q_dmem;
    end
  end

  // --- stage boundary: atomic commit to the renderer-visible bank ---
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        bank[i] <= '0;
      end
    end else if (commit_en) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        bank[i] <= shadow[i];
      end
    end
  end

  assign bus.VGA_address_dmem = addr;
  assign bus.busy             = busy;
  assign bus.frame_ready      = frame_ready;
  assign bus.overrun          = overrun;

  // Indices past the fetched window read as zero.
  assign bus.rd_data = (int'(bus.rd_index) < NUM_WORDS) ? bank[bus.rd_index] : '0;

endmodule

// File: doc/vga_state_fetcher.md
Name: vga_state_fetcher

Overview:
- Read-side client of dmem port B (the VGA port: address in, 32-bit data out, read-only).
- Once per video frame, on a frame_start pulse from the VGA timing block, burst-reads a fixed window of game-state words from dmem (Pacman/ghost positions, score, flags) into a shadow buffer.
- When the burst completes, commits the whole window atomically to a committed bank and pulses frame_ready.
- The renderer reads the committed bank through a combinational index port, so a frame never shows half-updated state.

Parameters:
- BASE_ADDR, 12'd1024, dmem word address of state word 0.
- NUM_WORDS, 8, words fetched per frame (1..2^IDX_W).
- IDX_W, 3, width of rd_index.
- READ_LATENCY, 2, edges from address presentation to data capture (1..4).

Ports:
- clock  in  1  master clock, same as dmem clock_b.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  single-cycle pulse, start of vertical blank.
- VGA_address_dmem  out  12  dmem port-B address.
- VGA_q_dmem  in  32  dmem port-B read data.
- rd_index  in  IDX_W  committed-bank word select.
- rd_data  out  32  committed-bank word at rd_index; combinational.
- busy  out  1  fetch in progress.
- frame_ready  out  1  one-cycle pulse, new bank committed.
- overrun  out  1  one-cycle pulse, frame_start dropped.

Behaviour:
- Reset (on a clock edge with reset=1):
  - state <= IDLE; VGA_address_dmem <= BASE_ADDR.
  - busy, frame_ready and overrun <= 0.
  - Committed bank and shadow cleared to 0; rd_data reads 0.
  - Reset overrides every other input, including mid-burst; the partial shadow is discarded and the committed bank is zeroed.
- States: IDLE, ISSUE, DRAIN, COMMIT.
- IDLE:
  - Address held at BASE_ADDR.
  - frame_start=1 at edge E0 -> ISSUE, busy<=1, address counter starts at 0.
- ISSUE:
  - VGA_address_dmem = BASE_ADDR + k during cycle k, where cycle k starts at edge E0+k, for k = 0..NUM_WORDS-1.
  - Address arithmetic is 12-bit and wraps modulo 4096.
  - After the last address -> DRAIN. Address holds at the last value until IDLE.
- Capture:
  - A READ_LATENCY-deep valid/index shift pipeline tracks issued reads.
  - Word k is sampled from VGA_q_dmem into shadow[k] on edge E0+k+READ_LATENCY.
  - Capture overlaps ISSUE (pipelined, one word per cycle, no bubbles).
- DRAIN: waits for outstanding captures. The edge that captures word NUM_WORDS-1 moves to COMMIT.
- COMMIT (one cycle): at edge E0+NUM_WORDS+READ_LATENCY:
  - bank <= shadow, all words at once;
  - frame_ready <= 1 for exactly one cycle;
  - busy <= 0; state -> IDLE.
- Commit visibility:
  - rd_data shows the new values in the same cycle frame_ready is high.
  - Before that edge it shows the complete previous frame, never a mix.
- frame_start in ISSUE, DRAIN or COMMIT: ignored, overrun <= 1 for one cycle; the current burst continues unaffected.
- frame_start held high for multiple cycles:
  - The first IDLE cycle starts a burst.
  - Each following cycle in which it is still high while busy pulses overrun.
- rd_index >= NUM_WORDS: rd_data = 0.
- Port B is read-only; the block never drives write data or a write enable.
- Any reset-free cycle with frame_start=0 in IDLE: all outputs hold.

Test Plan:
- Reset, then idle 5 cycles: VGA_address_dmem=1024, busy=0, frame_ready=0, rd_data=0 for rd_index 0..7.
- dmem words 1024..1031 preloaded with 32'hA0..32'hA7; frame_start pulse at edge E0:
  - addresses 1024..1031 appear on cycles E0..E0+7;
  - frame_ready pulses at edge E0+10;
  - rd_index=5 returns 32'hA5; busy high E0..E0+9.
- Word 1027 changed to 32'h55 mid-burst after its read: rd_data[3] stays at the old value until the next frame's commit, then reads 32'h55.
- frame_start re-pulsed at E0+4 during a burst: overrun pulses at E0+4; exactly one frame_ready at E0+10; no second burst starts.
- reset asserted at E0+6 mid-burst:
  - state IDLE, address 1024, bank all zero, no frame_ready;
  - a new frame_start then completes normally.
- BASE_ADDR=12'd4092, NUM_WORDS=8: addresses wrap 4092..4095, 0..3; shadow order preserved.
